// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared definitions for the UART blocks (uart_tx, uart_rx,
//                uart_echo_responder): frame width, default bit period and
//                the RX/TX state encodings.
//  Revision    : 1.0  initial release
// ============================================================================
package uart_pkg;

    localparam int DATA_BITS            = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 16;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_STOP      = 3'd3,
        RX_WAIT_HIGH = 3'd4
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_byte_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_byte_fifo
//  Description : Small synchronous byte FIFO holding bytes awaiting echo.
//                Pointers carry one extra wrap bit so full and empty are
//                distinguished without a separate counter. Read data is the
//                entry at the read pointer (first-word fall-through).
//  Revision    : 1.0  initial release
//
//  Ports
//    clk          rising-edge clock
//    i_rst_n      asynchronous active-low reset (empties the FIFO)
//    i_push       write i_push_data (ignored when full unless popping)
//    i_push_data  byte to store
//    i_pop        remove head entry (ignored when empty)
//    o_pop_data   current head entry
//    o_full       no free entry
//    o_empty      no stored entry
// ============================================================================
module uart_byte_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 i_rst_n,
    input  logic                 i_push,
    input  logic [DATA_BITS-1:0] i_push_data,
    input  logic                 i_pop,
    output logic [DATA_BITS-1:0] o_pop_data,
    output logic                 o_full,
    output logic                 o_empty
);

    localparam int c_AW = $clog2(DEPTH);

    logic [DATA_BITS-1:0] r_mem [DEPTH];
    logic [c_AW:0]        r_wr_ptr;
    logic [c_AW:0]        r_rd_ptr;
    logic                 w_do_push;
    logic                 w_do_pop;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                     (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);

    // A push while full is still accepted when the head leaves in the same
    // cycle: the freed slot is the one being written.
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    assign o_pop_data = r_mem[r_rd_ptr[c_AW-1:0]];

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: entries are only visible between push and pop.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[c_AW-1:0]] <= i_push_data;
    end

endmodule
`default_nettype wire

// File: rtl/uart_echo_responder.sv
`default_nettype none
// ============================================================================
//  Module      : uart_echo_responder
//  Description : Far-end UART peer. Receives 8N1 frames, buffers good bytes
//                in a small FIFO and retransmits them unchanged. Framing
//                errors and FIFO overflow are flagged, never echoed.
//  Revision    : 1.0  initial release
//
//  Ports
//    clk        rising-edge system clock
//    reset      asynchronous active-low reset
//    rx_serial  serial input from initiator, idle high, asynchronous
//    echo_en    allows the transmitter to start frames from the FIFO
//    tx_serial  serial output to initiator, idle high
//    rx_byte    last good received byte, held until the next good frame
//    rx_valid   one-cycle pulse, rx_byte updated
//    frame_err  one-cycle pulse, stop bit sampled low
//    overflow   one-cycle pulse, good byte dropped because FIFO full
//    tx_active  high while a frame (start..stop) is on tx_serial
//    tx_done    one-cycle pulse after the last stop-bit cycle
// ============================================================================
module uart_echo_responder
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_serial,
    input  logic                 echo_en,
    output logic                 tx_serial,
    output logic [DATA_BITS-1:0] rx_byte,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 overflow,
    output logic                 tx_active,
    output logic                 tx_done
);

    localparam int c_CW = $clog2(CLKS_PER_BIT);
    localparam int c_BW = $clog2(DATA_BITS);

    localparam logic [c_CW-1:0] c_BIT_LAST  = c_CW'(CLKS_PER_BIT - 1);
    localparam logic [c_CW-1:0] c_HALF_LAST = c_CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_BW-1:0] c_LAST_BIT  = c_BW'(DATA_BITS - 1);

    // ------------------------------------------------------------------
    // Input synchroniser (idles high so reset does not look like a start)
    // ------------------------------------------------------------------
    logic r_rx_meta;
    logic r_rx_sync;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= rx_serial;
            r_rx_sync <= r_rx_meta;
        end
    end

    // ------------------------------------------------------------------
    // FIFO hookup
    // ------------------------------------------------------------------
    rx_state_t            r_rx_state;
    logic [c_CW-1:0]      r_rx_cnt;
    logic [c_BW-1:0]      r_rx_bit;
    logic [DATA_BITS-1:0] r_rx_shift;

    tx_state_t            r_tx_state;
    logic [c_CW-1:0]      r_tx_cnt;
    logic [c_BW-1:0]      r_tx_bit;
    logic [DATA_BITS-1:0] r_tx_shift;

    logic                 w_rx_good;
    logic                 w_fifo_push;
    logic                 w_fifo_pop;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic [DATA_BITS-1:0] w_fifo_rd_data;

    // Good frame: stop bit sampled high at the end of the stop period.
    assign w_rx_good = (r_rx_state == RX_STOP) && (r_rx_cnt == c_BIT_LAST) &&
                       r_rx_sync;

    assign w_fifo_pop  = (r_tx_state == TX_IDLE) && echo_en && !w_fifo_empty;
    assign w_fifo_push = w_rx_good && (!w_fifo_full || w_fifo_pop);

    uart_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .i_rst_n     (reset),
        .i_push      (w_fifo_push),
        .i_push_data (r_rx_shift),
        .i_pop       (w_fifo_pop),
        .o_pop_data  (w_fifo_rd_data),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty)
    );

    // ------------------------------------------------------------------
    // RX FSM: mid-bit sampling from the synchronised line
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
            rx_byte    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overflow  <= 1'b0;
            case (r_rx_state)
                RX_IDLE: begin
                    r_rx_cnt <= '0;
                    r_rx_bit <= '0;
                    if (!r_rx_sync) r_rx_state <= RX_START;
                end
                RX_START: begin
                    // Half a bit in: a line already back high was a glitch.
                    if (r_rx_cnt == c_HALF_LAST) begin
                        r_rx_cnt   <= '0;
                        r_rx_state <= r_rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (r_rx_cnt == c_BIT_LAST) begin
                        r_rx_cnt   <= '0;
                        r_rx_shift <= {r_rx_sync, r_rx_shift[DATA_BITS-1:1]};
                        if (r_rx_bit == c_LAST_BIT) r_rx_state <= RX_STOP;
                        else                        r_rx_bit   <= r_rx_bit + 1'b1;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (r_rx_cnt == c_BIT_LAST) begin
                        r_rx_cnt <= '0;
                        if (r_rx_sync) begin
                            rx_byte    <= r_rx_shift;
                            rx_valid   <= 1'b1;
                            overflow   <= !w_fifo_push;
                            r_rx_state <= RX_IDLE;
                        end else begin
                            frame_err  <= 1'b1;
                            r_rx_state <= RX_WAIT_HIGH;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                RX_WAIT_HIGH: begin
                    // A held-low line (break) must not restart reception.
                    if (r_rx_sync) r_rx_state <= RX_IDLE;
                end
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // TX FSM: all outputs registered, tx_serial changes on bit boundaries
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            tx_serial  <= 1'b1;
            tx_active  <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (r_tx_state)
                TX_IDLE: begin
                    r_tx_cnt <= '0;
                    r_tx_bit <= '0;
                    if (w_fifo_pop) begin
                        r_tx_shift <= w_fifo_rd_data;
                        tx_serial  <= 1'b0;
                        tx_active  <= 1'b1;
                        r_tx_state <= TX_START;
                    end
                end
                TX_START: begin
                    if (r_tx_cnt == c_BIT_LAST) begin
                        r_tx_cnt   <= '0;
                        tx_serial  <= r_tx_shift[0];
                        r_tx_state <= TX_DATA;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (r_tx_cnt == c_BIT_LAST) begin
                        r_tx_cnt <= '0;
                        if (r_tx_bit == c_LAST_BIT) begin
                            tx_serial  <= 1'b1;
                            r_tx_state <= TX_STOP;
                        end else begin
                            // shift[0] is on the line; shift[1] goes next.
                            r_tx_bit   <= r_tx_bit + 1'b1;
                            tx_serial  <= r_tx_shift[1];
                            r_tx_shift <= {1'b0, r_tx_shift[DATA_BITS-1:1]};
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                TX_STOP: begin
                    if (r_tx_cnt == c_BIT_LAST) begin
                        r_tx_cnt   <= '0;
                        tx_active  <= 1'b0;
                        tx_done    <= 1'b1;
                        r_tx_state <= TX_IDLE;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                default: r_tx_state <= TX_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_echo_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_echo_responder
//  Description : Self-checking bench for uart_echo_responder. A serial
//                driver sends frames; monitors decode rx pulses and the
//                echoed tx waveform; a queue model holds the expected bytes.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_echo_responder;

    localparam int C       = 16;
    localparam int FRAME   = 10 * C;
    // Pin edge to rx_valid: stop sample at C/2+9C plus synchroniser and
    // output register; a few cycles of slack around that.
    localparam int LAT_MIN = C / 2 + 9 * C;
    localparam int LAT_MAX = LAT_MIN + 5;

    logic       clk       = 1'b0;
    logic       reset     = 1'b0;
    logic       rx_serial = 1'b1;
    logic       echo_en   = 1'b0;
    logic       tx_serial;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       frame_err;
    logic       overflow;
    logic       tx_active;
    logic       tx_done;

    uart_echo_responder #(
        .CLKS_PER_BIT (C),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_serial (rx_serial),
        .echo_en   (echo_en),
        .tx_serial (tx_serial),
        .rx_byte   (rx_byte),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .overflow  (overflow),
        .tx_active (tx_active),
        .tx_done   (tx_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- model and observation state ----------------
    logic [7:0] exp_rx_q[$];
    logic [7:0] exp_echo_q[$];
    logic [7:0] got_rx_q[$];
    logic [7:0] got_tx_q[$];
    int         rx_lat_q[$];
    int         tx_bad_q[$];
    int         act_len_q[$];
    int         exp_ferr = 0;
    int         n_ferr   = 0;
    int         n_ovf    = 0;
    int         n_done   = 0;
    int         ovf_at   = 0;
    int         cyc      = 0;
    int         last_start_cyc = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // RX-side pulse monitor
    initial forever begin
        @(negedge clk);
        if (rx_valid === 1'b1) begin
            got_rx_q.push_back(rx_byte);
            rx_lat_q.push_back(cyc - last_start_cyc);
        end
        if (frame_err === 1'b1) n_ferr++;
        if (overflow === 1'b1) begin
            n_ovf++;
            ovf_at = got_rx_q.size();
        end
    end

    // TX line decoder: captures a whole frame per cycle and compares it
    // with the ideal start/data/stop waveform of the decoded byte.
    initial begin
        logic [FRAME-1:0] samp;
        logic [7:0]       b;
        logic             e;
        int               bad;
        bit               aborted;
        forever begin
            @(negedge clk);
            if (reset === 1'b1 && tx_serial === 1'b0) begin
                samp    = '0;
                aborted = 1'b0;
                for (int k = 1; k < FRAME; k++) begin
                    @(negedge clk);
                    samp[k] = tx_serial;
                    if (reset !== 1'b1) aborted = 1'b1;
                end
                if (!aborted) begin
                    for (int j = 0; j < 8; j++) b[j] = samp[(j + 1) * C + C / 2];
                    bad = 0;
                    for (int k = 0; k < FRAME; k++) begin
                        if (k / C == 0)      e = 1'b0;
                        else if (k / C == 9) e = 1'b1;
                        else                 e = b[k / C - 1];
                        if (samp[k] !== e) bad++;
                    end
                    got_tx_q.push_back(b);
                    tx_bad_q.push_back(bad);
                end
            end
        end
    end

    // tx_active run lengths and tx_done placement
    initial begin
        int   run;
        logic prev;
        run  = 0;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_done === 1'b1) begin
                n_done++;
                check("done_align", {30'd0, prev, tx_active}, 32'd2);
            end
            if (reset !== 1'b1)          run = 0;
            else if (tx_active === 1'b1) run++;
            else if (run != 0) begin
                act_len_q.push_back(run);
                run = 0;
            end
            prev = tx_active;
        end
    end

    // ---------------- stimulus helpers ----------------
    // Called at a negedge, returns at a negedge right after the last bit.
    task automatic send_frame(input logic [7:0] b, input bit good, input int extra_low);
        rx_serial      = 1'b0;
        last_start_cyc = cyc;
        repeat (C) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_serial = b[i];
            repeat (C) @(negedge clk);
        end
        rx_serial = good;
        repeat (C) @(negedge clk);
        if (!good) begin
            repeat (extra_low * C) @(negedge clk);
            rx_serial = 1'b1;
            exp_ferr++;
        end else begin
            exp_rx_q.push_back(b);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_tx_frames(input int n, input int budget);
        int k;
        k = 0;
        while (got_tx_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (got_tx_q.size() < n) check("tx_wait_timeout", got_tx_q.size(), n);
        idle(4);
    endtask

    task automatic wait_tx_active(input int budget);
        int k;
        k = 0;
        while (tx_active !== 1'b1 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("tx_active_rise", {31'd0, tx_active}, 32'd1);
    endtask

    task automatic check_scenario(input string tag, input int exp_ovf);
        check({tag, ":rx_n"}, got_rx_q.size(), exp_rx_q.size());
        foreach (exp_rx_q[i])
            if (i < got_rx_q.size()) check({tag, ":rx_byte"}, {24'd0, got_rx_q[i]}, {24'd0, exp_rx_q[i]});
        foreach (rx_lat_q[i])
            check({tag, ":rx_lat"}, (rx_lat_q[i] >= LAT_MIN && rx_lat_q[i] <= LAT_MAX), 1);
        check({tag, ":tx_n"}, got_tx_q.size(), exp_echo_q.size());
        foreach (exp_echo_q[i])
            if (i < got_tx_q.size()) check({tag, ":tx_byte"}, {24'd0, got_tx_q[i]}, {24'd0, exp_echo_q[i]});
        foreach (tx_bad_q[i]) check({tag, ":tx_wave_bad_cycles"}, tx_bad_q[i], 0);
        check({tag, ":active_n"}, act_len_q.size(), exp_echo_q.size());
        foreach (act_len_q[i]) check({tag, ":active_len"}, act_len_q[i], FRAME);
        check({tag, ":done_n"}, n_done, exp_echo_q.size());
        check({tag, ":ferr_n"}, n_ferr, exp_ferr);
        check({tag, ":ovf_n"}, n_ovf, exp_ovf);
        exp_rx_q.delete();
        exp_echo_q.delete();
        got_rx_q.delete();
        got_tx_q.delete();
        rx_lat_q.delete();
        tx_bad_q.delete();
        act_len_q.delete();
        exp_ferr = 0;
        n_ferr   = 0;
        n_ovf    = 0;
        n_done   = 0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [7:0] b;
        bit         good;
        int         n_good;

        idle(3);
        check("rst_tx_serial", {31'd0, tx_serial}, 32'd1);
        check("rst_rx_byte",   {24'd0, rx_byte},   32'd0);
        check("rst_rx_valid",  {31'd0, rx_valid},  32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        check("rst_overflow",  {31'd0, overflow},  32'd0);
        check("rst_tx_active", {31'd0, tx_active}, 32'd0);
        check("rst_tx_done",   {31'd0, tx_done},   32'd0);
        reset   = 1'b1;
        echo_en = 1'b1;
        idle(4);

        // single echo
        send_frame(8'h55, 1'b1, 0);
        exp_echo_q.push_back(8'h55);
        wait_tx_frames(1, 3 * FRAME);
        check_scenario("single", 0);

        // back-to-back, no idle gap between frames
        send_frame(8'h93, 1'b1, 0);
        send_frame(8'hFF, 1'b1, 0);
        exp_echo_q.push_back(8'h93);
        exp_echo_q.push_back(8'hFF);
        wait_tx_frames(2, 4 * FRAME);
        check_scenario("b2b", 0);

        // framing error: stop bit low, line low for 3 bit times in total
        send_frame(8'hA5, 1'b0, 2);
        idle(2 * FRAME);
        check_scenario("ferr", 0);

        // glitch: 4-cycle low pulse
        rx_serial = 1'b0;
        idle(4);
        rx_serial = 1'b1;
        idle(20 * C);
        check_scenario("glitch", 0);

        // overflow with echo disabled, then echo with a mid-frame disable
        echo_en = 1'b0;
        for (int v = 1; v <= 5; v++) begin
            send_frame(v[7:0], 1'b1, 0);
            idle(C);
        end
        idle(FRAME);
        check("ovf_no_echo_n", got_tx_q.size(), 0);
        check("ovf_at_rx_idx", ovf_at, 5);
        echo_en = 1'b1;
        wait_tx_active(3 * C);
        echo_en = 1'b0;
        idle(2 * FRAME);
        check("en_low_one_frame", got_tx_q.size(), 1);
        echo_en = 1'b1;
        for (int v = 1; v <= 4; v++) exp_echo_q.push_back(v[7:0]);
        wait_tx_frames(4, 6 * FRAME);
        check_scenario("ovf", 1);

        // randomised good/bad frames with random gaps
        n_good = 0;
        for (int k = 0; k < 8; k++) begin
            b    = 8'($urandom);
            good = ($urandom_range(0, 3) != 0);
            send_frame(b, good, int'($urandom_range(0, 2)));
            if (good) begin
                exp_echo_q.push_back(b);
                n_good++;
            end
            idle(good ? int'($urandom_range(0, 3 * C)) : int'($urandom_range(C, 3 * C)));
        end
        wait_tx_frames(n_good, 12 * FRAME);
        idle(FRAME);
        check_scenario("rand", 0);

        // reset in the middle of a transmitted data bit, bytes still queued
        echo_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            send_frame(8'($urandom_range(1, 255)), 1'b1, 0);
            idle(C);
        end
        echo_en = 1'b1;
        wait_tx_active(3 * C);
        idle(3 * C + C / 2);
        reset = 1'b0;
        #1;
        check("rst_mid_tx_serial", {31'd0, tx_serial}, 32'd1);
        check("rst_mid_tx_active", {31'd0, tx_active}, 32'd0);
        @(negedge clk);
        check("rst_mid_rx_byte", {24'd0, rx_byte}, 32'd0);
        idle(4);
        reset = 1'b1;
        idle(3 * FRAME);
        check_scenario("reset", 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_echo_responder.md
# uart_echo_responder

Far-end UART peer that answers an initiator on the serial link: receives 8N1 frames on `rx_serial`, buffers each good byte in a 4-entry FIFO, and retransmits it unchanged on `tx_serial`. It sits opposite the existing `uart_tx`/`uart_rx` pair in loopback benches and on-board link checks, giving the initiator a protocol-correct remote end. Framing errors and FIFO overflow are flagged, never echoed.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per serial bit; even, ≥ 4.
- `FIFO_DEPTH`, 4: echo buffer entries; power of two.
- `clk`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `rx_serial`  in  1  serial line from initiator, idle high, asynchronous to `clk`.
- `echo_en`  in  1  when high, the transmitter may start frames from the FIFO.
- `tx_serial`  out  1  serial line to initiator, idle high.
- `rx_byte`  out  8  last good received byte; held until the next good frame.
- `rx_valid`  out  1  one-cycle pulse, `rx_byte` updated.
- `frame_err`  out  1  one-cycle pulse, stop bit sampled low.
- `overflow`  out  1  one-cycle pulse, good byte dropped because FIFO full.
- `tx_active`  out  1  high while a frame (start..stop) is on `tx_serial`.
- `tx_done`  out  1  one-cycle pulse at end of each transmitted frame.

## Operation
- **Reset values:**
  - `tx_serial`=1, all other outputs 0.
  - FIFO empty; both FSMs in IDLE.
  - Synchroniser flops = 1.
- **Input synchronisation:** `rx_serial` passes through a 2-flop synchroniser; all RX decisions use the synchronised value.
- **RX FSM:** states IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE → START on synced low.
  - START: count `CLKS_PER_BIT/2`. If the line is still low, go to DATA; if high, treat as a glitch and return to IDLE.
  - DATA: sample every `CLKS_PER_BIT` cycles, 8 bits, LSB first.
  - STOP: sample after `CLKS_PER_BIT`.
    - Sample 1: update `rx_byte`, pulse `rx_valid`, push to the FIFO (or pulse `overflow` if full), then return to IDLE.
    - Sample 0: pulse `frame_err`, discard the byte, go to WAIT_HIGH.
  - WAIT_HIGH: leave for IDLE only after the line is synced high. A break never produces false starts.
- **FIFO:** push on good frame only; pop by the TX FSM only.
  - Push and pop in the same cycle while full: both succeed, count unchanged.
  - Pop never occurs on empty; there is no empty bypass.
- **TX FSM:** states IDLE, START, DATA, STOP.
  - IDLE: if `echo_en` and the FIFO is non-empty, pop into a shift register and go to START.
  - START: drive low for `CLKS_PER_BIT` cycles.
  - DATA: 8 bits LSB first, `CLKS_PER_BIT` each.
  - STOP: drive high for `CLKS_PER_BIT` cycles, then return to IDLE.
- **`echo_en` low mid-frame:** the current frame completes; no further pops.
- **Reset mid-operation:** immediate abort, `tx_serial` forced high, buffered bytes lost.

## Timing
- **RX latency:** synced falling edge at cycle 0 → stop sample at cycle `CLKS_PER_BIT/2 + 9*CLKS_PER_BIT`. `rx_valid`/`frame_err`/`overflow` are registered the following cycle, giving 2 extra cycles from the pin.
- **TX frame:** exactly `10*CLKS_PER_BIT` cycles of `tx_active`=1.
  - `tx_serial` goes low the cycle after the pop.
  - `tx_done` pulses the cycle after the last stop cycle, with `tx_active`=0 that cycle.
  - The earliest next start bit is the cycle after `tx_done`, giving a minimum idle gap of 1 cycle plus the pop cycle.
- **Full duplex:** RX and TX run fully independently; receiving while transmitting is legal.

## Structure
- **Shared package `uart_pkg`:**
  - `DATA_BITS`=8.
  - Default `CLKS_PER_BIT`.
  - RX and TX state encodings, shared with `uart_tx`/`uart_rx`.
- **Sub-module `uart_byte_fifo`:**
  - Parameterised depth.
  - Pointers one bit wider than the address.
  - Full/empty outputs, registered storage.
- RX FSM, TX FSM and synchroniser stay in the top module.

## Test plan
All scenarios use `CLKS_PER_BIT`=16 and `echo_en`=1 unless stated.
- **Single echo:** drive frame 0x55 → `rx_valid` with `rx_byte`=0x55 at the specified cycle; `tx_serial` emits 0x55 start/LSB-first/stop at 16 cycles/bit; one `tx_done`.
- **Back-to-back:** frames 0x93 then 0xFF with no idle gap → both echoed in order; `tx_active` frames are 160 cycles each.
- **Framing error and overflow:**
  - 0xA5 frame with stop bit 0, line held low for 3 bit times → one `frame_err`, no `rx_valid`, no echo, no further starts until the line is high.
  - `echo_en`=0, send 5 bytes 0x01..0x05 → 4 `rx_valid` without `overflow`, 5th gives `overflow`. Raise `echo_en` → 0x01..0x04 echoed.
- **Glitch rejection:** 4-cycle low pulse on `rx_serial` → returns to IDLE; no outputs pulse.
- **Reset mid-operation:** assert `reset` mid-TX data bit → `tx_serial`=1 and `tx_active`=0 immediately. After release, FIFO is empty and no echo occurs.
